// File: rtl/game_pkg.sv
// Shared definitions for the game control unit and its datapath:
// state codes, board dimensions and the fixed track picture map.
package game_pkg;

   localparam int unsigned TRACK_LEN   = 24;
   localparam int unsigned NUM_TILES   = 12;
   localparam int unsigned PIC_W       = 3;
   localparam int unsigned MAX_PLAYERS = 4;
   localparam int unsigned POS_W       = 5;
   localparam int unsigned KEY_W       = 4;
   localparam int unsigned PLAYER_W    = 2;
   localparam int unsigned LFSR_W      = 8;

   typedef enum logic [2:0] {
      ST_SETUP   = 3'b000,
      ST_PLAYERS = 3'b001,
      ST_READY   = 3'b010,
      ST_PICK    = 3'b011,
      ST_CHECK   = 3'b100,
      ST_MISS    = 3'b101,
      ST_MOVE    = 3'b110,
      ST_OVER    = 3'b111
   } state_e;

   // Picture printed on track cell idx: (3*idx+1) mod 8.
   function automatic logic [PIC_W-1:0] track_pic(input logic [POS_W:0] idx);
      logic [7:0] t;
      t = 8'(idx) * 8'd3 + 8'd1;
      return PIC_W'(t);
   endfunction

endpackage

// File: rtl/game_datapath_btn_pulse.sv
// Button conditioner: 2-FF synchronizer followed by a registered
// rising-edge one-shot, so a held button yields a single pulse.
module btn_pulse (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   logic [2:0] sync_q;
   logic       pulse_q;

   // sync_q[1:0] is the synchronizer; sync_q[2] is the previous synchronized level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], btn_i};
         pulse_q <= sync_q[1] & ~sync_q[2];
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/game_datapath.sv
// Game datapath: confirm pulse, tile shuffle, player/turn bookkeeping,
// track positions and the go/win status flags for the control unit.
module game_datapath
   import game_pkg::*;
#(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          btn_c,
   input  logic [KEY_W-1:0]              key,
   input  logic [2:0]                    M,
   input  logic                          A,
   input  logic                          D,
   input  logic                          WR,
   output logic                          c,
   output logic                          go,
   output logic                          win,
   output logic [2:0]                    num_players,
   output logic [PLAYER_W-1:0]           cur_player,
   output logic [MAX_PLAYERS*POS_W-1:0]  pos_bus,
   output logic                          prompt
);

   state_e                st;
   logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
   logic [PIC_W-1:0]      hidden_q [NUM_TILES];
   logic [PIC_W-1:0]      hidden_d [NUM_TILES];
   logic [POS_W-1:0]      pos_q [MAX_PLAYERS];
   logic [POS_W-1:0]      pos_d [MAX_PLAYERS];
   logic [2:0]            np_q, np_d;
   logic [PLAYER_W-1:0]   cur_q, cur_d;
   logic                  go_q, go_d;
   logic                  win_q, win_d;
   logic                  prompt_q;
   logic                  c_pulse;

   logic [KEY_W-1:0]      key_idx;
   logic [POS_W:0]        n_sel;
   logic                  key_ok;
   logic                  match;

   btn_pulse u_btn_c (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_c),
      .pulse_o (c_pulse)
   );

   assign st      = state_e'(M);
   assign key_idx = key - KEY_W'(1);
   assign key_ok  = (key != '0) && (key <= KEY_W'(NUM_TILES));
   // Select compares against the cell the active player would step onto.
   assign n_sel   = {1'b0, pos_q[cur_q]} + (POS_W+1)'(1);
   assign match   = key_ok && (hidden_q[key_idx] == track_pic(n_sel));

   always_comb begin
      lfsr_d   = lfsr_q;
      hidden_d = hidden_q;
      pos_d    = pos_q;
      np_d     = np_q;
      cur_d    = cur_q;
      go_d     = go_q;
      win_d    = win_q;

      case (st)
         ST_SETUP: begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (WR && c_pulse) begin
               for (int j = 0; j < NUM_TILES; j++) begin
                  hidden_d[j] = PIC_W'(j) + lfsr_q[2:0];
               end
            end
         end
         ST_PLAYERS: begin
            if (WR && (key >= KEY_W'(2)) && (key <= KEY_W'(4))) begin
               np_d = key[2:0];
            end
         end
         ST_PICK: begin
            if (key != '0) begin
               go_d  = match;
               win_d = match && (n_sel == (POS_W+1)'(TRACK_LEN - 1));
            end
         end
         ST_MISS: begin
            if (c_pulse) begin
               cur_d = ({1'b0, cur_q} + 3'd1 == np_q) ? '0 : cur_q + PLAYER_W'(1);
            end
         end
         default: ;
      endcase

      // Advance targets the player active before any same-cycle turn pass.
      if (D && (st != ST_OVER) && (pos_q[cur_q] != POS_W'(TRACK_LEN - 1))) begin
         pos_d[cur_q] = pos_q[cur_q] + POS_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q   <= LFSR_SEED;
         hidden_q <= '{default: '0};
         pos_q    <= '{default: '0};
         np_q     <= 3'd2;
         cur_q    <= '0;
         go_q     <= 1'b0;
         win_q    <= 1'b0;
         prompt_q <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         hidden_q <= hidden_d;
         pos_q    <= pos_d;
         np_q     <= np_d;
         cur_q    <= cur_d;
         go_q     <= go_d;
         win_q    <= win_d;
         prompt_q <= A;
      end
   end

   assign c           = c_pulse;
   assign go          = go_q;
   assign win         = win_q;
   assign num_players = np_q;
   assign cur_player  = cur_q;
   assign pos_bus     = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};
   assign prompt      = prompt_q;

endmodule

// File: tb/tb_game_datapath.sv
// Directed bench for game_datapath: a rule-level reference model is
// compared against every output each cycle, plus hand-computed checks.
module tb_game_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_c = 1'b0;
   logic [3:0]  key = '0;
   logic [2:0]  M = '0;
   logic        A = 1'b0;
   logic        D = 1'b0;
   logic        WR = 1'b0;
   logic        c, go, win, prompt;
   logic [2:0]  num_players;
   logic [1:0]  cur_player;
   logic [19:0] pos_bus;

   int passed = 0;
   int total  = 0;

   game_datapath dut (
      .clk(clk), .rst(rst), .btn_c(btn_c), .key(key), .M(M), .A(A), .D(D),
      .WR(WR), .c(c), .go(go), .win(win), .num_players(num_players),
      .cur_player(cur_player), .pos_bus(pos_bus), .prompt(prompt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] lfsr_m = 8'hA5;
   int hidden_m [12];
   int pos_m [4];
   int np_m = 2, cur_m = 0, go_m = 0, win_m = 0, c_m = 0, prompt_m = 0;
   int cyc = 0, due = -10, btn_prev = 0, shuffle_s = -1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_m = 8'hA5;
         foreach (hidden_m[j]) hidden_m[j] = 0;
         foreach (pos_m[p]) pos_m[p] = 0;
         np_m = 2; cur_m = 0; go_m = 0; win_m = 0; c_m = 0; prompt_m = 0;
         due = -10; btn_prev = 0;
      end else begin
         int c_old, s, n;
         cyc++;
         c_old = c_m;
         s = int'(lfsr_m) % 8;
         if (M == 3'd3 && key != 0) begin
            if (key <= 12) begin
               n = pos_m[cur_m] + 1;
               go_m  = (hidden_m[key-1] == (3*n + 1) % 8) ? 1 : 0;
               win_m = (go_m == 1 && n == 23) ? 1 : 0;
            end else begin
               go_m = 0; win_m = 0;
            end
         end
         if (M == 3'd0) begin
            lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
            if (WR && c_old == 1) begin
               foreach (hidden_m[j]) hidden_m[j] = (j + s) % 8;
               shuffle_s = s;
            end
         end
         if (M == 3'd1 && WR && key >= 2 && key <= 4) np_m = int'(key);
         if (D && M != 3'd7 && pos_m[cur_m] < 23) pos_m[cur_m]++;
         if (M == 3'd5 && c_old == 1) cur_m = (cur_m + 1 == np_m) ? 0 : cur_m + 1;
         if (btn_c && btn_prev == 0) due = cyc + 2;
         btn_prev = int'(btn_c);
         c_m = (cyc == due) ? 1 : 0;
         prompt_m = int'(A);
      end
   end

   always @(negedge clk) begin
      check("c", int'(c), c_m);
      check("go", int'(go), go_m);
      check("win", int'(win), win_m);
      check("num_players", int'(num_players), np_m);
      check("cur_player", int'(cur_player), cur_m);
      check("pos_bus", int'(pos_bus),
            pos_m[0] + 32*pos_m[1] + 1024*pos_m[2] + 32768*pos_m[3]);
      check("prompt", int'(prompt), prompt_m);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic press(input int hold);
      btn_c = 1'b1;
      tick(hold);
      btn_c = 1'b0;
      tick(6);
   endtask

   task automatic select(input int k);
      M = 3'd3; key = 4'(k);
      tick(1);
      key = '0; M = 3'd4;
      tick(1);
   endtask

   initial begin
      int first, cnt, s, kmatch, kwin;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_np", int'(num_players), 2);
      check("rst_pos", int'(pos_bus), 0);
      check("rst_c", int'(c), 0);

      // Confirm pulse: one cycle, three edges after the rise.
      M = 3'd2;
      btn_c = 1'b1;
      first = 0; cnt = 0;
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         if (k == 10) btn_c = 1'b0;
         if (c) begin
            cnt++;
            if (first == 0) first = k;
         end
      end
      check("c_count", cnt, 1);
      check("c_delay", first, 3);

      // Shuffle during setup.
      M = 3'd0; WR = 1'b1;
      press(3);
      WR = 1'b0;
      check("shuffled", (shuffle_s >= 0) ? 1 : 0, 1);
      s = shuffle_s;

      // Player count.
      M = 3'd1; WR = 1'b1; key = 4'd3;
      tick(1);
      check("np_set", int'(num_players), 3);
      key = 4'd5; tick(1);
      key = 4'd1; tick(1);
      key = '0; WR = 1'b0;
      check("np_keep", int'(num_players), 3);

      // Match against track[1] = 4, then a non-matching key.
      kmatch = ((4 - s + 8) % 8) + 1;
      select(kmatch);
      check("match_go", int'(go), 1);
      check("match_win", int'(win), 0);
      select((kmatch % 8) + 1);
      check("miss_go", int'(go), 0);

      // Turn rotation over three players.
      M = 3'd5;
      press(4);
      press(4);
      check("rot_cur2", int'(cur_player), 2);
      press(4);
      check("rot_wrap", int'(cur_player), 0);

      // Advance to 22, winning select onto track[23] = 6, saturation.
      M = 3'd6; D = 1'b1;
      tick(22);
      D = 1'b0;
      check("pos22", int'(pos_bus[4:0]), 22);
      kwin = ((6 - s + 8) % 8) + 1;
      select(kwin);
      check("win_go", int'(go), 1);
      check("win_win", int'(win), 1);
      M = 3'd6; D = 1'b1; tick(1); D = 1'b0;
      check("pos23", int'(pos_bus[4:0]), 23);
      D = 1'b1; tick(1); D = 1'b0;
      check("pos_sat", int'(pos_bus[4:0]), 23);

      // Out-of-range key.
      select(14);
      check("oor_go", int'(go), 0);
      check("oor_win", int'(win), 0);
      check("oor_pos", int'(pos_bus[4:0]), 23);

      // Asynchronous reset mid-run.
      A = 1'b1;
      tick(3);
      check("pre_prompt", int'(prompt), 1);
      #1 rst = 1'b1;
      #1;
      check("arst_prompt", int'(prompt), 0);
      check("arst_np", int'(num_players), 2);
      check("arst_pos", int'(pos_bus), 0);
      check("arst_cur", int'(cur_player), 0);
      check("arst_go", int'(go), 0);
      A = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/game_datapath.md
Name: game_datapath

Overview:
- Datapath partner of the game control unit. Consumes the control unit's `M` (3-bit state code), `A`, `D` and `WR`.
- Produces the status inputs the control unit branches on: `c` (confirm pulse), `go` (tile match) and `win`.
- Owns player count, current player, per-player track positions and the hidden-tile shuffle.
- Sits between the board I/O (keypad, confirm button) and the control unit.

Parameters:
- TRACK_LEN, 24: track cells, 0..TRACK_LEN-1; goal cell is TRACK_LEN-1.
- NUM_TILES, 12: hidden tiles, selected by key 1..NUM_TILES.
- PIC_W, 3: picture id width (8 pictures).
- LFSR_SEED, 8'hA5: shuffle LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_c  in  1  raw confirm button, asynchronous to clk
- key  in  4  keypad code; 0 = no key
- M  in  3  control state code
- A  in  1  awaiting-key flag from control
- D  in  1  advance pulse from control
- WR  in  1  setup-write enable from control
- c  out  1  confirm, one-cycle pulse
- go  out  1  selected tile matches next cell
- win  out  1  this move reaches the goal
- num_players  out  3  2..4 once set
- cur_player  out  2  active player index
- pos_bus  out  4*5  positions; player p at bits [5p+4:5p]
- prompt  out  1  equals A, registered, for the LED

Behaviour:
- Reset values (async, immediate):
  - outputs: c=0, go=0, win=0, num_players=2, cur_player=0, pos_bus=0, prompt=0.
  - internal: LFSR=LFSR_SEED, sync FFs=0, all hidden tiles=0.
- Confirm:
  - btn_c passes through a 2-FF synchronizer, then a rising-edge detector.
  - c is high exactly one cycle per press, 3 cycles after the btn_c rise.
  - A held button produces no repeats.
- LFSR:
  - 8-bit, shifts left every cycle while M==000.
  - Feedback = b7^b5^b4^b3 into b0; frozen in all other states.
- Shuffle:
  - Triggered when M==000 && WR && c.
  - hidden[j] = (j + lfsr[2:0]) mod 8, for j=0..NUM_TILES-1, using the current LFSR value.
- Track pictures: constant, track[i] = (3*i+1) mod 8.
- Player count: when M==001 && WR && key in 2..4, num_players <= key[2:0]. Other keys are ignored.
- Tile select, when M==011 && key!=0:
  - If key in 1..NUM_TILES:
    - t = hidden[key-1]
    - n = pos[cur_player] + 1
    - go <= (t == track[n])
    - win <= go_next && (n == TRACK_LEN-1)
  - If key > NUM_TILES: go <= 0, win <= 0.
  - go and win are registered on that edge, so both are valid throughout M==100 and M==110.
  - They hold until the next select.
- Advance:
  - When D==1: pos[cur_player] <= pos[cur_player]+1, saturating at TRACK_LEN-1.
  - cur_player does not change.
- Turn pass:
  - When M==101 && c: cur_player <= (cur_player+1 == num_players) ? 0 : cur_player+1.
- M==111: positions, cur_player and num_players are frozen; go and win hold.
- Simultaneous events:
  - D and a tile select in the same cycle: D updates pos; the select uses the pre-update pos.
  - Turn pass and D in the same cycle: D applies to the old cur_player.
- Reset mid-game: all state is cleared immediately; the LFSR restarts from the seed.
- Unused M codes: no state change.

Decomposition:
- Shared package game_pkg holds:
  - the state-code constants for M (ST_SETUP=000, ST_PLAYERS=001, ST_READY=010, ST_PICK=011, ST_CHECK=100, ST_MISS=101, ST_MOVE=110, ST_OVER=111);
  - TRACK_LEN, NUM_TILES, PIC_W;
  - the track picture function.
- The control unit and this block both import game_pkg.
- One sub-module: btn_pulse, the 2-FF synchronizer plus rising-edge one-shot. It is reusable for other buttons.

Test Plan:
- Reset and confirm:
  - Assert rst mid-run: all outputs reach reset values with no clock edge.
  - Pulse btn_c high for 10 cycles: c high for exactly 1 cycle, 3 cycles after the rise.
- Players:
  - M=001, WR=1, key=3: num_players=3.
  - key=5, then key=1: num_players unchanged.
- Match:
  - Shuffle with the bench-modelled lfsr[2:0]=s; cur_player 0 at pos 0.
  - In M=011, present key with (key-1+s)%8 == track[1] = 4: go=1, win=0 during M=100.
  - A non-matching key: go=0.
- Rotation:
  - num_players=3, cur_player=2; M=101 with a c pulse: cur_player=0.
- Win and saturation:
  - Preload pos[0]=22 via D pulses.
  - Select the tile matching track[23]=6: go=1, win=1.
  - D pulse: pos=23. A further D: pos stays 23.
- Out-of-range key:
  - M=011, key=14: go=0, win=0, pos unchanged.
